// File: rtl/logistic_pkg.sv
// logistic_pkg: shared widths, FSM state encoding and default seed for the logistic-map scheduler
package logistic_pkg;
  localparam int DW  = 17;
  localparam int MUW = 18;
  localparam int CW  = 9;
  localparam logic [DW-1:0] DEFAULT_SEED = 17'h10240;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_e;
endpackage

// File: rtl/logistic_step.sv
// logistic_step: one combinational logistic-map step f(x) = mu * x * (1 - x) in unsigned fixed point
module logistic_step
  import logistic_pkg::*;
(
  input  logic [DW-1:0]  x_i,
  input  logic [MUW-1:0] mu_i,
  output logic [DW-1:0]  f_o
);
  logic [DW:0]       comp;
  logic [2*DW:0]     term;
  logic [DW:0]       t;
  logic [MUW+DW:0]   prod;
  // 1 - x is formed one bit wider so that x = 0 yields the full-scale value 2^DW
  assign comp = {1'b1, {DW{1'b0}}} - {1'b0, x_i};
  assign term = {{(DW+1){1'b0}}, x_i} * {{DW{1'b0}}, comp};
  assign t    = (DW+1)'(term >> (DW-1));
  assign prod = {{(DW+1){1'b0}}, mu_i} * {{MUW{1'b0}}, t};
  // the top product bit is dropped on purpose: the result wraps rather than saturates
  assign f_o  = DW'(prod >> MUW);
endmodule

// File: rtl/logistic_scheduler.sv
// logistic_scheduler: shares one logistic step unit round-robin across LANES trajectories
module logistic_scheduler
  import logistic_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [CW-1:0]            times,
  input  logic [MUW-1:0]           mu,
  input  logic [DW-1:0]            seed_base,
  output logic                     busy,
  output logic                     done,
  output logic [CW-1:0]            iter_count,
  input  logic [$clog2(LANES)-1:0] rd_lane,
  output logic [DW-1:0]            rd_data
);
  localparam int PW = $clog2(LANES);
  localparam logic [PW-1:0] LAST = PW'(LANES - 1);
  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  iter_q, iter_d;
  logic [CW-1:0]  times_q;
  logic [MUW-1:0] mu_q;
  logic [DW-1:0]  seed_q;
  logic [DW-1:0]  lane_q [LANES];
  logic [DW-1:0]  step_f, lane_wd;
  logic           lane_we, accept;
  logistic_step u_step (
    .x_i  (lane_q[ptr_q]),
    .mu_i (mu_q),
    .f_o  (step_f)
  );
  assign lane_wd    = (state_q == LOAD) ? seed_q + DW'(ptr_q) : step_f;
  assign busy       = (state_q == LOAD) || (state_q == RUN);
  assign done       = (state_q == FIN);
  assign iter_count = iter_q;
  assign rd_data    = lane_q[rd_lane];
  // sequencing: accept start in IDLE, seed lanes, iterate rounds, then a single done cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    iter_d  = iter_q;
    lane_we = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        ptr_d   = '0;
        iter_d  = '0;
        state_d = LOAD;
      end
      LOAD: begin
        lane_we = 1'b1;
        ptr_d   = ptr_q + PW'(1);
        if (ptr_q == LAST) state_d = (times_q != '0) ? RUN : FIN;
      end
      RUN: begin
        lane_we = 1'b1;
        ptr_d   = ptr_q + PW'(1);
        if (ptr_q == LAST) begin
          iter_d  = iter_q + CW'(1);
          state_d = (iter_q + CW'(1) == times_q) ? FIN : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // control registers and the run parameters captured at an accepted start
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      iter_q  <= '0;
      times_q <= '0;
      mu_q    <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      iter_q  <= iter_d;
      if (accept) begin
        times_q <= times;
        mu_q    <= mu;
        seed_q  <= seed_base;
      end
    end
  end
  // lane state: the lane under the pointer takes its seed or its next iterate
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else if (lane_we) begin
      lane_q[ptr_q] <= lane_wd;
    end
  end
endmodule

// File: doc/logistic_scheduler.md
Name: logistic_scheduler

Overview:
- Time-multiplexes one shared logistic-map step datapath across LANES independent trajectories.
- Each lane's seed differs by its lane index.
- Sequences seed load, round-robin iteration for a programmed count, and a done handshake.
- Sits between the pixel/control logic, which supplies mu, times and seed and reads lane results, and the single step datapath. This replaces per-lane duplicated multipliers.

Parameters:
- LANES, 4, number of trajectories sharing the step unit (power of 2, 2..16)
- DW, 17, state/seed width, unsigned fixed point
- MUW, 18, mu width, unsigned fixed point
- CW, 9, iteration-count width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-low reset
- start  in  1  request a run; sampled only in IDLE
- times  in  CW  iterations per lane; latched at accepted start
- mu  in  MUW  map parameter; latched at accepted start
- seed_base  in  DW  lane k seed = seed_base + k (mod 2^DW); latched at accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when all lanes have completed times iterations
- iter_count  out  CW  completed full rounds in the current or last run
- rd_lane  in  log2(LANES)  lane select for readback
- rd_data  out  DW  combinational current state of lane rd_lane

Behaviour:
- Reset, asynchronous and active-low. Resets to IDLE with busy=0, done=0, iter_count=0, all lane registers=0 (so rd_data=0), lane pointer=0 and latched regs=0. Reset asserted mid-run aborts immediately; no done pulse is produced.
- FSM states are IDLE, LOAD, RUN and FIN.
- IDLE: start=1 latches times, mu and seed_base, clears iter_count and the lane pointer, then moves to LOAD. start is ignored in every other state, with no queuing.
- LOAD: one lane per cycle writes lane[p] <= seed_base_l + p, and p increments. After lane LANES-1:
  - go to RUN if times_l != 0;
  - otherwise go to FIN.
- RUN: one lane per cycle writes lane[p] <= f(lane[p]), and p increments with wrap-around. When p wraps from LANES-1 to 0, iter_count increments. When the new iter_count equals times_l, go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle done rises.
- Step function f(x), all intermediates unsigned:
  - term[2*DW-1:0] = x * (2^DW - x), computed in DW+1 bits before the multiply;
  - t = term[2*DW-1:DW-1];
  - prod = mu_l * t, 36 bits;
  - f = prod[34:18], dropping bit 35 with no saturation.
- Edge values of f: x=0 gives f=0. x=2^16 with mu=2^18-1 gives f=65535.
- f is combinational, single-cycle. State writeback is registered, so there is no pipeline hazard because each lane is touched once per round.
- Latency from the start-accept edge to the done pulse is LANES + LANES*times + 1 cycles. For the defaults with times=10, that is 45 cycles.
- rd_data is valid in any state. During RUN it shows intermediate values. After FIN it holds final values until the next LOAD overwrites them.
- Changes to mu, times or seed_base mid-run have no effect.

Decomposition:
- Package logistic_pkg holds DW, MUW, CW, the FSM state enum, and the default seed constant 17'h10240.
- Sub-module logistic_step is the pure combinational f(x, mu) above, instantiated once and reused by future single-lane blocks.
- Lane state is an LANES x DW register array inside the scheduler.

Test Plan:
1. Reset values: drive RST=0 mid-RUN with times=100 -> busy=0, done=0, iter_count=0, rd_data=0 for all lanes. No done pulse ever appears. The next start then runs normally.
2. Zero-count run: seed_base=17'h10240, times=0 -> done at cycle LANES+1=5. Lanes 0..3 read 17'h10240..17'h10243. iter_count=0.
3. Single step: seed_base=17'h10000, mu=18'h3FFFF, times=1, LANES=4 -> lane0 reads 65535. Lanes 1..3 match the golden model. done at cycle 9.
4. Zero mu: mu=0, times=3 -> all lanes read 0. iter_count=3. done exactly 17 cycles after start.
5. Start during busy: pulse start at cycles 2 and 20 of a times=10 run with different mu -> results match the first mu only, done pulses once, and the bench confirms the second start is ignored.
6. Random regression: 200 runs with random seed_base/mu/times under 32 -> every lane matches the bit-exact C model and the done timing formula holds.
